// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Single-port arbiter and instruction-fetch stage in front of the processor's
// mem_block RAM. Each cycle the RAM port goes to one of three owners, highest
// priority first:
//    DATA  : a pending load/store (dreq=1 and no dack in this cycle)
//    FETCH : fetch enabled, not halted, and the IR is empty or being consumed
//    NONE  : the port idles on the program counter
// The block keeps the program counter and a one-entry instruction register
// that it hands to the processor with a valid/ready handshake.
//
// Optional feature (compile-time macro FETCH_HALT_EN):
//    defined   - fetching an all-ones word sets 'halted' and stops further
//                fetches until a jump or reset; data accesses continue.
//    undefined - 'halted' is tied to 0 and all-ones is an ordinary word.
//
// Parameters
//    ADDRBITS  RAM address width, also the PC width
//    WIDTH     data / instruction word width
//
// Ports
//    Clock, Resetn             rising-edge clock, asynchronous active-low reset
//    mem_addr/mem_data/mem_wr_en  RAM address, write data and write enable
//    mem_q                     combinational RAM read data for mem_addr
//    run                       fetch enable
//    jump, jump_addr           PC redirect strobe and target
//    ir, ir_valid, ir_ready    instruction register and its handshake
//    pc                        address of the next fetch
//    dreq, dwe, daddr, dwdata  data request (dwe=1 store, 0 load)
//    dack, drdata              one-cycle completion pulse and load result
//    halted                    fetch stopped on the halt word
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int ADDRBITS = 5,
   parameter int WIDTH    = 16
) (
   input  logic                Clock,
   input  logic                Resetn,
   output logic [ADDRBITS-1:0] mem_addr,
   output logic [WIDTH-1:0]    mem_data,
   output logic                mem_wr_en,
   input  logic [WIDTH-1:0]    mem_q,
   input  logic                run,
   input  logic                jump,
   input  logic [ADDRBITS-1:0] jump_addr,
   output logic [WIDTH-1:0]    ir,
   output logic                ir_valid,
   input  logic                ir_ready,
   output logic [ADDRBITS-1:0] pc,
   input  logic                dreq,
   input  logic                dwe,
   input  logic [ADDRBITS-1:0] daddr,
   input  logic [WIDTH-1:0]    dwdata,
   output logic                dack,
   output logic [WIDTH-1:0]    drdata,
   output logic                halted
);

   // Fetch-side condition. FULL depends on ir_ready, so it is a decode of the
   // registered IR status plus the consumer's handshake, not a stored state.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2
   } fetch_state_t;

   fetch_state_t        state;
   logic                own_data;
   logic                own_fetch;
   logic [ADDRBITS-1:0] fetch_addr;

   logic [ADDRBITS-1:0] pc_nxt;
   logic [WIDTH-1:0]    ir_nxt;
   logic                ir_valid_nxt;
   logic                dack_nxt;
   logic [WIDTH-1:0]    drdata_nxt;

`ifdef FETCH_HALT_EN
   logic                halted_r;
   logic                halted_nxt;
   assign halted = halted_r;
`else
   assign halted = 1'b0;
`endif

   always_comb begin
      state = IDLE;
      if (run && !halted) begin
         state = (ir_valid && !ir_ready) ? FULL : FETCH;
      end
   end

   // A request seen in the dack cycle belongs to the access just completed,
   // so it is ignored; data accesses therefore run at most every other cycle.
   assign own_data   = dreq && !dack;
   assign own_fetch  = !own_data && (state == FETCH);
   assign fetch_addr = jump ? jump_addr : pc;

   // RAM port drive. Held at the reset values while Resetn is low so that a
   // store in flight when reset hits cannot write the RAM.
   always_comb begin
      mem_addr  = pc;
      mem_data  = '0;
      mem_wr_en = 1'b0;
      if (own_data) begin
         mem_addr  = daddr;
         mem_data  = dwdata;
         mem_wr_en = dwe;
      end else if (own_fetch) begin
         mem_addr  = fetch_addr;
      end
      if (!Resetn) begin
         mem_addr  = '0;
         mem_data  = '0;
         mem_wr_en = 1'b0;
      end
   end

   // Next-state logic for PC, IR, data completion and halt.
   always_comb begin
      pc_nxt       = pc;
      ir_nxt       = ir;
      ir_valid_nxt = ir_valid;
      dack_nxt     = own_data;
      drdata_nxt   = drdata;
`ifdef FETCH_HALT_EN
      halted_nxt   = halted_r;
`endif

      if (own_data && !dwe) begin
         drdata_nxt = mem_q;
      end

      if (own_fetch) begin
         // A jump coinciding with a fetch fetches the target directly,
         // which replaces (and so flushes) the old IR contents.
         ir_nxt       = mem_q;
         ir_valid_nxt = 1'b1;
         pc_nxt       = fetch_addr + ADDRBITS'(1);
`ifdef FETCH_HALT_EN
         halted_nxt   = &mem_q;
`endif
      end else if (jump) begin
         // Redirect without a fetch: the IR content is stale, drop it even
         // if the consumer is not ready, and leave any halt.
         pc_nxt       = jump_addr;
         ir_valid_nxt = 1'b0;
`ifdef FETCH_HALT_EN
         halted_nxt   = 1'b0;
`endif
      end else if (ir_valid && ir_ready) begin
         ir_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         pc       <= '0;
         ir       <= '0;
         ir_valid <= 1'b0;
         dack     <= 1'b0;
         drdata   <= '0;
`ifdef FETCH_HALT_EN
         halted_r <= 1'b0;
`endif
      end else begin
         pc       <= pc_nxt;
         ir       <= ir_nxt;
         ir_valid <= ir_valid_nxt;
         dack     <= dack_nxt;
         drdata   <= drdata_nxt;
`ifdef FETCH_HALT_EN
         halted_r <= halted_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Bench for mem_access_ctrl with a behavioural RAM and a reference model of
// the arbiter/fetch rules kept in plain variables. Directed scenarios with
// literal expectations come first, then randomized traffic. Every cycle the
// DUT outputs are compared against the model half a cycle after the edge.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

   localparam int AB = 5;
   localparam int W  = 16;

   logic          Clock = 1'b0;
   logic          Resetn;
   logic [AB-1:0] mem_addr;
   logic [W-1:0]  mem_data;
   logic          mem_wr_en;
   logic [W-1:0]  mem_q;
   logic          run;
   logic          jump;
   logic [AB-1:0] jump_addr;
   logic [W-1:0]  ir;
   logic          ir_valid;
   logic          ir_ready;
   logic [AB-1:0] pc;
   logic          dreq;
   logic          dwe;
   logic [AB-1:0] daddr;
   logic [W-1:0]  dwdata;
   logic          dack;
   logic [W-1:0]  drdata;
   logic          halted;

   mem_access_ctrl #(.ADDRBITS(AB), .WIDTH(W)) dut (
      .Clock(Clock), .Resetn(Resetn),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr_en(mem_wr_en),
      .mem_q(mem_q),
      .run(run), .jump(jump), .jump_addr(jump_addr),
      .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .pc(pc),
      .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
      .dack(dack), .drdata(drdata), .halted(halted)
   );

   always #5 Clock = ~Clock;

   // Behavioural RAM seen by the DUT; written only from the stimulus process.
   logic [W-1:0] ram [32];
   assign mem_q = ram[mem_addr];

   // Reference model state.
   logic [W-1:0]  ref_ram [32];
   logic [AB-1:0] m_pc;
   logic [W-1:0]  m_ir;
   logic          m_irv;
   logic          m_dack;
   logic [W-1:0]  m_drd;
   logic          m_halt;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = '0; m_ir = '0; m_irv = 1'b0; m_dack = 1'b0; m_drd = '0; m_halt = 1'b0;
   endtask

   // One clock edge of the specified behaviour, using inputs as held now.
   task automatic model_step();
      logic          od;
      logic          of;
      logic [AB-1:0] a;
      od = dreq && !m_dack;
      of = !od && run && !m_halt && (!m_irv || ir_ready);
      a  = jump ? jump_addr : m_pc;
      if (od && !dwe) m_drd = ref_ram[daddr];
      if (od && dwe)  ref_ram[daddr] = dwdata;
      m_dack = od;
      if (of) begin
         m_ir  = ref_ram[a];
         m_irv = 1'b1;
         m_pc  = a + 5'd1;
`ifdef FETCH_HALT_EN
         m_halt = (m_ir == 16'hFFFF);
`endif
      end else if (jump) begin
         m_pc   = jump_addr;
         m_irv  = 1'b0;
         m_halt = 1'b0;
      end else if (m_irv && ir_ready) begin
         m_irv = 1'b0;
      end
   endtask

   task automatic check_all();
      logic          od;
      logic          of;
      logic [AB-1:0] ea;
      logic [W-1:0]  ed;
      logic          ew;
      od = dreq && !m_dack;
      of = !od && run && !m_halt && (!m_irv || ir_ready);
      ea = m_pc; ed = '0; ew = 1'b0;
      if (od) begin
         ea = daddr; ed = dwdata; ew = dwe;
      end else if (of) begin
         ea = jump ? jump_addr : m_pc;
      end
      if (!Resetn) begin
         ea = '0; ed = '0; ew = 1'b0;
      end
      chk("mem_addr",  32'(mem_addr),  32'(ea));
      chk("mem_data",  32'(mem_data),  32'(ed));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(ew));
      chk("ir",        32'(ir),        32'(m_ir));
      chk("ir_valid",  32'(ir_valid),  32'(m_irv));
      chk("pc",        32'(pc),        32'(m_pc));
      chk("dack",      32'(dack),      32'(m_dack));
      chk("drdata",    32'(drdata),    32'(m_drd));
      chk("halted",    32'(halted),    32'(m_halt));
   endtask

   // Advance one clock: RAM write and model update at the rising edge,
   // then return at the falling edge ready for new inputs.
   task automatic tick();
      @(posedge Clock);
      if (mem_wr_en) ram[mem_addr] = mem_data;
      if (Resetn) model_step();
      @(negedge Clock);
   endtask

   task automatic settle();
      #1;
      check_all();
   endtask

   initial begin
      Resetn = 1'b0; run = 1'b0; jump = 1'b0; jump_addr = '0; ir_ready = 1'b0;
      dreq = 1'b0; dwe = 1'b0; daddr = '0; dwdata = '0;
      for (int i = 0; i < 32; i++) begin
         ram[i] = 16'($urandom);
         if (ram[i] == 16'hFFFF) ram[i] = 16'h0000;
      end
      ram[0] = 16'hF000; ram[1] = 16'h0001; ram[2] = 16'hF800; ram[7] = 16'h0777;
      ram[20] = 16'hFFFF;
      for (int i = 0; i < 32; i++) ref_ram[i] = ram[i];
      model_reset();

      // Reset state
      #2;
      check_all();
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_ir_valid", 32'(ir_valid), 32'd0);
      chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
      @(negedge Clock);
      @(negedge Clock);
      Resetn = 1'b1; run = 1'b1; ir_ready = 1'b1;
      settle();

      // Sequential fetch
      tick(); settle();
      chk("seq_ir0", 32'(ir), 32'hF000); chk("seq_pc0", 32'(pc), 32'd1);
      tick(); settle();
      chk("seq_ir1", 32'(ir), 32'h0001); chk("seq_pc1", 32'(pc), 32'd2);
      tick();
      ir_ready = 1'b0;
      settle();
      chk("seq_ir2", 32'(ir), 32'hF800); chk("seq_pc2", 32'(pc), 32'd3);

      // Backpressure holds the IR and PC
      tick(); settle();
      tick(); settle();
      chk("bp_ir", 32'(ir), 32'hF800); chk("bp_valid", 32'(ir_valid), 32'd1);
      chk("bp_pc", 32'(pc), 32'd3); chk("bp_wr_en", 32'(mem_wr_en), 32'd0);

      // Store collides with fetch
      ir_ready = 1'b1; dreq = 1'b1; dwe = 1'b1; daddr = 5'd4; dwdata = 16'h1234;
      settle();
      chk("st_wr_en", 32'(mem_wr_en), 32'd1); chk("st_addr", 32'(mem_addr), 32'd4);
      tick();
      dreq = 1'b0;
      settle();
      chk("st_dack", 32'(dack), 32'd1); chk("st_pc_held", 32'(pc), 32'd3);
      chk("st_wr_end", 32'(mem_wr_en), 32'd0);
      tick(); settle();
      chk("st_dack_drop", 32'(dack), 32'd0);

      // Load back the stored word
      dreq = 1'b1; dwe = 1'b0; daddr = 5'd4;
      settle();
      tick();
      dreq = 1'b0;
      settle();
      chk("ld_dack", 32'(dack), 32'd1); chk("ld_data", 32'(drdata), 32'h1234);

      // Jump during a full IR
      ir_ready = 1'b0;
      settle();
      tick(); settle();
      jump = 1'b1; jump_addr = 5'd7;
      settle();
      tick();
      jump = 1'b0;
      settle();
      chk("jmp_valid", 32'(ir_valid), 32'd0); chk("jmp_pc", 32'(pc), 32'd7);
      tick(); settle();
      chk("jmp_ir", 32'(ir), 32'h0777); chk("jmp_pc2", 32'(pc), 32'd8);

      // PC wrap
      ir_ready = 1'b1; jump = 1'b1; jump_addr = 5'd30;
      settle();
      tick();
      jump = 1'b0;
      settle();
      chk("wrap_pc31", 32'(pc), 32'd31);
      tick(); settle();
      chk("wrap_pc0", 32'(pc), 32'd0);

      // Asynchronous reset during a store cycle
      dreq = 1'b1; dwe = 1'b1; daddr = 5'd9; dwdata = 16'hABCD;
      settle();
      chk("mr_wr_before", 32'(mem_wr_en), 32'd1);
      #1 Resetn = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("mr_wr_en", 32'(mem_wr_en), 32'd0); chk("mr_pc", 32'(pc), 32'd0);
      chk("mr_valid", 32'(ir_valid), 32'd0); chk("mr_addr", 32'(mem_addr), 32'd0);
      tick();
      dreq = 1'b0;
      Resetn = 1'b1;
      settle();
      chk("mr_no_write", 32'(ram[9]), 32'(ref_ram[9]));

`ifdef FETCH_HALT_EN
      // Halt on an all-ones word, then resume with a jump
      ram[2] = 16'hFFFF; ref_ram[2] = 16'hFFFF;
      tick(); settle();
      tick(); settle();
      tick(); settle();
      chk("halt_set", 32'(halted), 32'd1); chk("halt_ir", 32'(ir), 32'hFFFF);
      tick(); settle();
      chk("halt_pc", 32'(pc), 32'd3);
      jump = 1'b1; jump_addr = 5'd0;
      settle();
      tick();
      jump = 1'b0;
      settle();
      chk("halt_clr", 32'(halted), 32'd0); chk("halt_jpc", 32'(pc), 32'd0);
      tick(); settle();
      chk("halt_resume", 32'(pc), 32'd1);
`endif

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (dreq && m_dack) begin
            dreq = 1'b0;
         end else if (!dreq && $urandom_range(3) == 0) begin
            dreq   = 1'b1;
            dwe    = 1'($urandom_range(1));
            daddr  = 5'($urandom);
            dwdata = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
         end
         jump      = ($urandom_range(7) == 0);
         jump_addr = 5'($urandom);
         ir_ready  = ($urandom_range(3) != 0);
         run       = ($urandom_range(15) != 0);
         settle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
